// File: rtl/seg_display_scheduler_if.sv
// Request/data/ack bundle between the two display requesters and the scheduler.
// The requester side (master) drives req and its two 16-bit values and
// receives the one-cycle ack pulses; the scheduler side (slave) is the mirror.
interface seg_display_scheduler_if;
  logic [1:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [1:0]  ack;

  modport master (output req, output data0, output data1, input ack);
  modport slave  (input req, input data0, input data1, output ack);
endinterface

// File: rtl/seg_display_scheduler.sv
// Four-digit multiplexed seven-segment display shared by two requesters.
// A slot counter scans the digits with a blanking gap at the start of each
// slot. Requesters win ownership round-robin; an owner keeps the display for
// at least DWELL full frames before a waiting rival may take over. Writes land
// in a shadow register that is copied to the visible value only on a frame
// boundary, so a frame never shows a mix of two values.
module seg_display_scheduler #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK    = 2000,
  parameter int DWELL    = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  seg_display_scheduler_if.slave  bus,
  output logic [6:0]              seg,
  output logic [3:0]              digit_sel,
  output logic                    DP,
  output logic                    owner,
  output logic                    owner_valid
);

  localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam int              DWW       = $clog2(DWELL + 1);
  localparam logic [DWW-1:0]  DWELL_MAX = DWW'(DWELL);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Scan and display registers
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_idx;
  logic [15:0]    r_disp;
  logic [6:0]     r_seg;
  logic [3:0]     r_dsel;

  // Ownership registers
  state_t         r_state;
  logic           r_owner;
  logic           r_owner_valid;
  logic           r_rr;
  logic [DWW-1:0] r_dwell;
  logic [15:0]    r_shadow;
  logic [1:0]     r_ack;

  // Combinational helpers and next-state values
  logic           w_slot_wrap;
  logic           w_frame;
  logic           w_blank;
  logic [3:0]     w_nibble;
  logic [1:0]     w_elig;
  logic           w_other;
  logic           w_grant;
  logic [15:0]    w_data_grant;
  logic [15:0]    w_data_own;
  logic [15:0]    w_data_other;
  state_t         w_nxt_state;
  logic           w_nxt_owner;
  logic           w_nxt_valid;
  logic           w_nxt_rr;
  logic [DWW-1:0] w_nxt_dwell;
  logic [15:0]    w_nxt_shadow;
  logic [1:0]     w_nxt_ack;

  assign w_slot_wrap  = (r_cnt == CNT_LAST);
  assign w_frame      = w_slot_wrap && (r_idx == 2'd3);
  assign w_blank      = (int'(r_cnt) < BLANK);
  assign w_nibble     = r_disp[{r_idx, 2'b00} +: 4];
  // A requester whose ack is showing this cycle cannot be accepted again yet.
  assign w_elig       = bus.req & ~r_ack;
  assign w_other      = ~r_owner;
  assign w_grant      = w_elig[r_rr] ? r_rr : ~r_rr;
  assign w_data_grant = w_grant ? bus.data1 : bus.data0;
  assign w_data_own   = r_owner ? bus.data1 : bus.data0;
  assign w_data_other = w_other ? bus.data1 : bus.data0;

  // Slot counter and digit index; the index advances on every slot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Visible value refresh at frame boundaries and registered segment/digit drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= 16'h0000;
      r_seg  <= 7'b1111111;
      r_dsel <= 4'b0000;
    end else begin
      if (w_frame) begin
        r_disp <= r_shadow;
      end
      if (!r_owner_valid || w_blank) begin
        r_seg  <= 7'b1111111;
        r_dsel <= 4'b0000;
      end else begin
        r_seg  <= hex_to_seg(w_nibble);
        r_dsel <= 4'b0001 << r_idx;
      end
    end
  end

  // Ownership decision: first grant, same-owner updates, dwell-gated handover.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_owner  = r_owner;
    w_nxt_valid  = r_owner_valid;
    w_nxt_rr     = r_rr;
    w_nxt_dwell  = r_dwell;
    w_nxt_shadow = r_shadow;
    w_nxt_ack    = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_elig != 2'b00) begin
          w_nxt_state  = ST_OWN;
          w_nxt_owner  = w_grant;
          w_nxt_valid  = 1'b1;
          w_nxt_dwell  = {DWW{1'b0}};
          w_nxt_shadow = w_data_grant;
          w_nxt_ack    = w_grant ? 2'b10 : 2'b01;
        end else begin
          w_nxt_state  = ST_IDLE;
        end
      end
      ST_OWN: begin
        if ((r_dwell == DWELL_MAX) && w_elig[w_other]) begin
          // Handover wins over a simultaneous same-owner write, which waits.
          w_nxt_owner  = w_other;
          w_nxt_rr     = r_owner;
          w_nxt_dwell  = {DWW{1'b0}};
          w_nxt_shadow = w_data_other;
          w_nxt_ack    = w_other ? 2'b10 : 2'b01;
        end else begin
          if (w_elig[r_owner]) begin
            w_nxt_shadow = w_data_own;
            w_nxt_ack    = r_owner ? 2'b10 : 2'b01;
          end else begin
            w_nxt_shadow = r_shadow;
          end
          if (w_frame && (r_dwell != DWELL_MAX)) begin
            w_nxt_dwell = r_dwell + DWW'(1);
          end else begin
            w_nxt_dwell = r_dwell;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // Ownership state register; reset also drops any ack in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_owner_valid <= 1'b0;
      r_rr          <= 1'b0;
      r_dwell       <= {DWW{1'b0}};
      r_shadow      <= 16'h0000;
      r_ack         <= 2'b00;
    end else begin
      r_state       <= w_nxt_state;
      r_owner       <= w_nxt_owner;
      r_owner_valid <= w_nxt_valid;
      r_rr          <= w_nxt_rr;
      r_dwell       <= w_nxt_dwell;
      r_shadow      <= w_nxt_shadow;
      r_ack         <= w_nxt_ack;
    end
  end

  assign bus.ack     = r_ack;
  assign seg         = r_seg;
  assign digit_sel   = r_dsel;
  assign DP          = 1'b1;
  assign owner       = r_owner;
  assign owner_valid = r_owner_valid;

endmodule

// File: doc/seg_display_scheduler.md
SEG_DISPLAY_SCHEDULER -- requirements
Module: seg_display_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV, 100000, clk cycles per digit slot (SCAN_DIV > BLANK).
REQ-002 SHALL have parameter BLANK, 2000, blanking cycles at start of each slot (>= 0).
REQ-003 SHALL have parameter DWELL, 50, minimum full frames an owner keeps the display (>= 1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  2  per-requester update request; held until acked.
REQ-007 SHALL have port data0  input  16  requester 0 value, four hex nibbles.
REQ-008 SHALL have port data1  input  16  requester 1 value.
REQ-009 SHALL have port ack  output  2  one-cycle registered accept pulse per requester.
REQ-010 SHALL have port seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 SHALL have port digit_sel  output  4  one-hot digit enable, active-high, registered.
REQ-012 SHALL have port DP  output  1  decimal point, tied 1 (off).
REQ-013 SHALL have port owner  output  1  index of current owner.
REQ-014 SHALL have port owner_valid  output  1  high once any requester has been granted.

Function
REQ-015 SHALL run a slot counter 0..SCAN_DIV-1 and a 2-bit digit index advancing 0,1,2,3,0 on counter wrap; a frame is four slots.
REQ-016 SHALL drive digit index k with digit_sel = 1<<k and seg = hex decode of disp[4k+3:4k].
REQ-017 SHALL decode hex as active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 SHALL force digit_sel=0000 and seg=1111111 while slot counter < BLANK, and at all times while owner_valid=0.
REQ-019 SHALL register seg/digit_sel: outputs reflect counter state with exactly one cycle latency.
REQ-020 SHALL keep a 16-bit shadow register; disp loads from shadow only on the cycle the digit index wraps 3->0 (frame boundary), so no frame shows mixed values.
REQ-021 SHALL use states IDLE and OWN; IDLE only after reset.
REQ-022 IDLE: on any req, SHALL grant req[rr] if set else the other (rr = round-robin pointer, 0 after reset), load shadow from its data, set owner, owner_valid=1, clear dwell count, go OWN.
REQ-023 OWN: req[owner] set SHALL load shadow from data_owner (same-owner update), regardless of dwell.
REQ-024 OWN: dwell count SHALL increment at each frame boundary, saturating at DWELL.
REQ-025 OWN: when dwell = DWELL and req[~owner] set, SHALL switch owner to ~owner, load its data, clear dwell, set rr = old owner; this takes priority over a simultaneous same-owner request, which stays pending.
REQ-026 OWN: req[~owner] before dwell = DWELL SHALL stay pending, unacked, without affecting the current owner.
REQ-027 Every accept SHALL produce ack[i]=1 on the following cycle only; a requester SHALL NOT be accepted again in the cycle its ack is high.
REQ-028 At most one accept per cycle; ack SHALL never be 11.
REQ-029 A shadow load on the same cycle as a frame boundary SHALL reach disp at the next frame boundary, not the current one.
REQ-030 Owner values SHALL persist indefinitely with no requests; no timeout release.

Reset
REQ-031 While rst=1 at a clock edge SHALL set: state IDLE, counters 0, digit index 0, dwell 0, rr 0, shadow=disp=16'h0000, ack=00, seg=1111111, digit_sel=0000, owner=0, owner_valid=0; DP=1 always.
REQ-032 Reset mid-operation SHALL discard pending requests and in-flight acks; no ack after the reset cycle unless re-requested.

Verification (SCAN_DIV=8, BLANK=2, DWELL=2)
REQ-033 Reset then no req for 100 cycles -> digit_sel=0000, seg=1111111, ack=00, owner_valid=0.
REQ-034 req=01, data0=16'h1234 -> ack=01 one cycle later; after next frame boundary slots show digit_sel 0001/0010/0100/1000 with seg 0011001/0110000/0100100/1111001, blank for 2 cycles each slot.
REQ-035 Both req=11 from IDLE -> requester 0 granted; requester 1 acked only after 2 frame boundaries; owner=1, rr=0.
REQ-036 Owner 0 writes 16'hAAAA then 16'h5555 within one frame -> both acked; next frame shows only 5555, never a mix.
REQ-037 At dwell=DWELL, req=11 same cycle -> ack=10, owner=1; requester 0 stays pending.
REQ-038 rst asserted one cycle after an accept -> no ack pulse, outputs at reset values next cycle.
